mem_sequencer: RTL and testbench
================================

Name: mem_sequencer

Overview:
Multi-cycle sequencer that lets the single-cycle ARMv4 core share one unified memory port between instruction fetch and load/store. Each instruction runs fetch -> execute -> optional data access -> commit. The block drives the core's instruction input and returns load data to it. A one-cycle commit strobe gates the core's register, CPSR and PC updates. Sits between the processor and the external memory/bus.

Parameters:
bus, 32, data/address width
TIMEOUT, 16, max consecutive wait cycles for mem_ready before bus error (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
fetch_addr  in  bus  current PC from core
instr  out  bus  latched instruction presented to core
cpu_mre  in  1  core load request (combinational from decode)
cpu_mwe  in  1  core store request
cpu_addr  in  bus  core data address
cpu_wdata  in  bus  core store data
cpu_rdata  out  bus  latched load data to core
commit  out  1  one-cycle strobe: core may update regs/CPSR/PC
mem_addr  out  bus  memory address
mem_wdata  out  bus  memory write data
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_rdata  in  bus  memory read data
mem_ready  in  1  memory completes current access this cycle
bus_err  out  1  sticky timeout flag
instret  out  32  committed-instruction counter
cycles  out  32  cycle counter since reset

Behaviour:
- Reset (reset==0 at a rising edge): state=S_IDLE, instr=0, cpu_rdata=0, commit=0, bus_err=0, instret=0, cycles=0, wait counter=0. While reset==0, mem_re, mem_we and commit are forced 0 combinationally. Reset mid-access abandons the access; no commit.
- States: S_IDLE, S_FETCH, S_EXEC, S_DATA, S_WB.
- S_IDLE: strobes 0. Next state is S_FETCH.
- S_FETCH: mem_addr=fetch_addr, mem_re=1. On mem_ready: instr<=mem_rdata, go to S_EXEC. Otherwise stay.
- S_EXEC: instr is stable and the core decodes.
  - If cpu_mre|cpu_mwe: go to S_DATA.
  - Otherwise commit=1 this cycle and go to S_FETCH.
  - If both cpu_mre and cpu_mwe are set, the store wins (mem_we only).
- S_DATA: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_re=cpu_mre&~cpu_mwe, mem_we=cpu_mwe. On mem_ready: for a load, cpu_rdata<=mem_rdata; go to S_WB.
- S_WB: commit=1, go to S_FETCH.
- Latency with zero-wait memory: non-memory instruction takes 2 cycles (FETCH, EXEC); load/store takes 4 cycles.
- mem_re/mem_we/mem_addr are Moore-style decodes of state (plus core inputs in S_DATA), held stable until mem_ready. mem_wdata = cpu_wdata in every state.
- Timeout: the wait counter increments each cycle in S_FETCH/S_DATA without mem_ready and clears on state change. If the TIMEOUT-th consecutive cycle also lacks mem_ready:
  - bus_err<=1 (sticky until reset);
  - go to S_FETCH;
  - no commit; a timed-out fetch retries the same address.
  - mem_ready arriving on the TIMEOUT-th cycle counts as success.
- Counters: cycles increments every non-reset cycle. instret increments on each commit. Both wrap 0xFFFFFFFF->0.
- commit is never asserted in two consecutive cycles.

Decomposition:
- Package vallhalla_seq_pkg: state enum (S_IDLE..S_WB), default TIMEOUT constant, counter width constant (32).
- One sub-module, wait_timer: counter with clear/enable and expired output, parameter TIMEOUT.

Test Plan:
- Zero-wait memory, ADD (0xE0810002) at fetch_addr 0x0: mem_re in cycle 1 after reset release; commit in cycle 2; instret=1; instr=0xE0810002.
- LDR, cpu_mre=1, cpu_addr=0x100, memory returns 0xDEADBEEF after 3 wait cycles: mem_addr=0x100 held 4 cycles; cpu_rdata=0xDEADBEEF; single commit in S_WB.
- STR, cpu_mwe=1, cpu_addr=0x40, cpu_wdata=0x12345678: exactly one mem_we cycle with addr 0x40 and data 0x12345678; mem_re=0 in S_DATA; commit follows.
- TIMEOUT=16, mem_ready held 0 in S_FETCH: bus_err rises after cycle 16, FSM re-enters S_FETCH at the same address, instret unchanged. Ready on cycle 16 instead: no bus_err.
- reset=0 asserted during S_DATA of a store: mem_we=0 in that cycle, no commit, all outputs at reset values next cycle, S_IDLE then S_FETCH after release.
- 100 back-to-back zero-wait ALU instructions: instret=100, cycles=200 (+1 idle), commit never on adjacent cycles. Preload instret near wrap to check 0xFFFFFFFF->0.

Source files
------------

// File: rtl/vallhalla_seq_pkg.sv
// Shared definitions for the memory sequencer that time-multiplexes one
// unified memory port between instruction fetch and load/store accesses.
// Contents: sequencer state encoding, default wait-timeout depth, counter
// width, and a helper that identifies the states which wait on mem_ready.
package vallhalla_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_DATA  = 3'd3,
        S_WB    = 3'd4
    } seq_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam int unsigned CNT_W           = 32;

    // True for the states that hold a memory access open until mem_ready.
    function automatic logic is_wait_state(input seq_state_e s);
        return (s == S_FETCH) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive cycles a memory access has been left waiting.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-low reset
//   clr     - return the count to zero (access finished or no access open)
//   en      - one more cycle without mem_ready
//   expired - combinational: this is the TIMEOUT-th consecutive waiting cycle
module wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Holds values 0..TIMEOUT-1, so TIMEOUT >= 2 always gives at least 1 bit.
    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_limit_s;

    assign at_limit_s = (cnt_q == CW'(TIMEOUT - 1));
    assign expired    = en & at_limit_s;

    // Next count: clear, advance, or wrap to zero once the limit fires.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en) begin
            if (at_limit_s) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer letting a single-cycle core share one memory port
// between instruction fetch and load/store. Each instruction runs
// FETCH -> EXEC -> (DATA -> WB) and commit pulses once at the end.
// Ports:
//   clk, reset            - clock; synchronous active-low reset
//   fetch_addr / instr    - PC from core / latched instruction to core
//   cpu_mre, cpu_mwe      - core load / store request (store wins if both)
//   cpu_addr, cpu_wdata   - core data address / store data
//   cpu_rdata             - latched load data to core
//   commit                - one-cycle strobe allowing the core to update state
//   mem_addr, mem_wdata   - memory address / write data
//   mem_re, mem_we        - memory read / write strobes
//   mem_rdata, mem_ready  - memory read data / access completes this cycle
//   bus_err               - sticky flag: an access waited TIMEOUT cycles
//   instret, cycles       - committed-instruction and cycle counters
module mem_sequencer
    import vallhalla_seq_pkg::*;
#(
    parameter int unsigned      BUS          = 32,
    parameter int unsigned      TIMEOUT      = DEFAULT_TIMEOUT,
    parameter logic [CNT_W-1:0] INSTRET_INIT = {CNT_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUS-1:0]   fetch_addr,
    output logic [BUS-1:0]   instr,
    input  logic             cpu_mre,
    input  logic             cpu_mwe,
    input  logic [BUS-1:0]   cpu_addr,
    input  logic [BUS-1:0]   cpu_wdata,
    output logic [BUS-1:0]   cpu_rdata,
    output logic             commit,
    output logic [BUS-1:0]   mem_addr,
    output logic [BUS-1:0]   mem_wdata,
    output logic             mem_re,
    output logic             mem_we,
    input  logic [BUS-1:0]   mem_rdata,
    input  logic             mem_ready,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_e       state_q, state_d;
    logic [BUS-1:0]   instr_q, instr_d;
    logic [BUS-1:0]   rdata_q, rdata_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic mem_req_s;
    logic load_s;
    logic waiting_s;
    logic expired_s;
    logic mem_re_s;
    logic mem_we_s;
    logic commit_s;

    assign mem_req_s = cpu_mre | cpu_mwe;
    // A request with both bits set is treated as a store.
    assign load_s    = cpu_mre & ~cpu_mwe;
    assign waiting_s = is_wait_state(state_q) & ~mem_ready;

    // Clearing whenever no wait is in progress also covers every state change.
    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (~waiting_s),
        .en      (waiting_s),
        .expired (expired_s)
    );

    // Moore-style memory-port and commit decode from the current state.
    always_comb begin
        mem_addr = fetch_addr;
        mem_re_s = 1'b0;
        mem_we_s = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_re_s = 1'b1;
            end
            S_EXEC: begin
                commit_s = ~mem_req_s;
            end
            S_DATA: begin
                mem_addr = cpu_addr;
                mem_re_s = load_s;
                mem_we_s = cpu_mwe;
            end
            S_WB: begin
                commit_s = 1'b1;
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    // Strobes are gated by reset so an abandoned access never reaches memory.
    assign mem_re    = mem_re_s & reset;
    assign mem_we    = mem_we_s & reset;
    assign commit    = commit_s & reset;
    assign mem_wdata = cpu_wdata;

    assign instr     = instr_q;
    assign cpu_rdata = rdata_q;
    assign bus_err   = bus_err_q;
    assign instret   = instret_q;
    assign cycles    = cycles_q;

    // Next-state, latch and counter logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        cycles_d  = cycles_q + CNT_ONE;
        if (commit_s) begin
            instret_d = instret_q + CNT_ONE;
        end else begin
            instret_d = instret_q;
        end
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // Ready on the last allowed cycle still counts as success.
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    state_d = S_EXEC;
                end else if (expired_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (mem_req_s) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DATA: begin
                if (mem_ready) begin
                    if (load_s) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = S_WB;
                end else if (expired_s) begin
                    // Abandon without commit; the core refetches the same PC.
                    bus_err_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            instr_q   <= {BUS{1'b0}};
            rdata_q   <= {BUS{1'b0}};
            bus_err_q <= 1'b0;
            instret_q <= INSTRET_INIT;
            cycles_q  <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
            cycles_q  <= cycles_d;
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer. A small memory model answers fetches
// from a word queue and data accesses after a programmable number of wait
// cycles; expected commits are queued as instructions are supplied and are
// matched when the sequencer raises commit.
module tb_mem_sequencer;

    localparam logic [31:0] WRAP_INIT = 32'hFFFF_FFC0;

    logic        clk;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        cpu_mre;
    logic        cpu_mwe;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    logic [31:0] instr, cpu_rdata, mem_addr, mem_wdata, instret, cycles;
    logic        commit, mem_re, mem_we, bus_err;

    logic [31:0] w_instr, w_cpu_rdata, w_mem_addr, w_mem_wdata, w_instret, w_cycles;
    logic        w_commit, w_mem_re, w_mem_we, w_bus_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic        chk_rdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ifetch_q[$];
    exp_t        mon_e;
    int          fetch_lat = 0;
    int          data_lat  = 0;
    int          wcnt      = 0;
    logic [31:0] dmem_word = 32'h0;
    bit          prev_commit = 1'b0;

    mem_sequencer #(.BUS(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .instr(instr),
        .cpu_mre(cpu_mre), .cpu_mwe(cpu_mwe), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .commit(commit),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err), .instret(instret), .cycles(cycles)
    );

    // Second instance whose instret starts near the wrap point.
    mem_sequencer #(.BUS(32), .TIMEOUT(16), .INSTRET_INIT(WRAP_INIT)) dut_wrap (
        .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .instr(w_instr),
        .cpu_mre(cpu_mre), .cpu_mwe(cpu_mwe), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(w_cpu_rdata), .commit(w_commit),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_re(w_mem_re),
        .mem_we(w_mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(w_bus_err), .instret(w_instret), .cycles(w_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: responds 2 time units after each rising edge.
    task automatic memory_model();
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            if (!reset) begin
                wcnt = 0;
            end else if (mem_we || (mem_re && cpu_mre && (mem_addr == cpu_addr) && (mem_addr != fetch_addr))) begin
                if (wcnt >= data_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = dmem_word;
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else if (mem_re && ifetch_q.size() != 0) begin
                if (wcnt >= fetch_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = ifetch_q.pop_front();
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    endtask

    // Scoreboard side: every commit must match the oldest queued instruction.
    task automatic commit_monitor();
        forever begin
            @(negedge clk);
            if (reset && commit) begin
                total++;
                if (prev_commit) begin
                    bad++;
                    $display("FAIL commit_adjacent: commit=1 in consecutive cycles, required a gap");
                end
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL commit_unexpected: commit=1 with instr=%h, required no commit", instr);
                end else begin
                    mon_e = sb.pop_front();
                    if (instr !== mon_e.instr) begin
                        bad++;
                        $display("FAIL commit_instr: got %h, required %h", instr, mon_e.instr);
                    end
                    if (mon_e.chk_rdata) begin
                        total++;
                        if (cpu_rdata !== mon_e.rdata) begin
                            bad++;
                            $display("FAIL commit_rdata: got %h, required %h", cpu_rdata, mon_e.rdata);
                        end
                    end
                end
            end
            prev_commit = reset && commit;
        end
    endtask

    task automatic supply_instr(input logic [31:0] w, input logic chk, input logic [31:0] rd);
        exp_t e;
        e.instr     = w;
        e.chk_rdata = chk;
        e.rdata     = rd;
        ifetch_q.push_back(w);
        sb.push_back(e);
    endtask

    // Returns 1 time unit after the first edge that sees reset released (cycle 0, S_IDLE).
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_mre = 1'b0; cpu_mwe = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        fetch_addr = 32'h0; fetch_lat = 0; data_lat = 0; dmem_word = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        ifetch_q.delete();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({mem_re, mem_we, commit} !== 3'b000) begin
            bad++;
            $display("FAIL reset_strobes: re/we/commit=%b, required 000", {mem_re, mem_we, commit});
        end
        do_reset();
        @(negedge clk);
        total++;
        if ({instr, cpu_rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data: instr=%h rdata=%h, required 0", instr, cpu_rdata);
        end
        total++;
        if ({commit, bus_err, mem_re, mem_we} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b, required 0000", {commit, bus_err, mem_re, mem_we});
        end
        total++;
        if ({instret, cycles} !== 64'h0) begin
            bad++;
            $display("FAIL reset_counters: instret=%0d cycles=%0d, required 0", instret, cycles);
        end
        total++;
        if (w_instret !== WRAP_INIT) begin
            bad++;
            $display("FAIL reset_instret_init: got %h, required %h", w_instret, WRAP_INIT);
        end
    endtask

    task automatic test_alu();
        do_reset();
        supply_instr(32'hE081_0002, 1'b0, 32'h0);
        @(negedge clk);
        total++;
        if (mem_re !== 1'b0) begin
            bad++;
            $display("FAIL alu_idle_re: got %b, required 0", mem_re);
        end
        @(negedge clk);
        total++;
        if ({mem_re, commit, mem_addr} !== {1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL alu_fetch: re=%b commit=%b addr=%h, required 1 0 0", mem_re, commit, mem_addr);
        end
        @(negedge clk);
        total++;
        if ({commit, instr} !== {1'b1, 32'hE081_0002}) begin
            bad++;
            $display("FAIL alu_commit: commit=%b instr=%h, required 1 e0810002", commit, instr);
        end
        @(negedge clk);
        total++;
        if ({instret, cycles, commit} !== {32'd1, 32'd3, 1'b0}) begin
            bad++;
            $display("FAIL alu_after: instret=%0d cycles=%0d commit=%b, required 1 3 0", instret, cycles, commit);
        end
    endtask

    task automatic test_load();
        int n_addr = 0;
        int n_we = 0;
        int n_commit = 0;
        int commit_at = -1;
        do_reset();
        cpu_mre = 1'b1; cpu_addr = 32'h100; data_lat = 3; dmem_word = 32'hDEAD_BEEF;
        supply_instr(32'hE591_0000, 1'b1, 32'hDEAD_BEEF);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_re && mem_addr == 32'h100) n_addr++;
            if (mem_we) n_we++;
            if (commit) begin
                n_commit++;
                commit_at = c;
            end
        end
        total++;
        if (n_addr != 4 || n_we != 0) begin
            bad++;
            $display("FAIL load_data_phase: read cycles=%0d writes=%0d, required 4 0", n_addr, n_we);
        end
        total++;
        if (n_commit != 1 || commit_at != 7) begin
            bad++;
            $display("FAIL load_commit: count=%0d cycle=%0d, required 1 at 7", n_commit, commit_at);
        end
        total++;
        if ({cpu_rdata, instret} !== {32'hDEAD_BEEF, 32'd1}) begin
            bad++;
            $display("FAIL load_result: rdata=%h instret=%0d, required deadbeef 1", cpu_rdata, instret);
        end
    endtask

    // Variant 1 also raises cpu_mre: the store must win.
    task automatic test_store();
        for (int v = 0; v < 2; v++) begin
            int n_we = 0;
            int n_we_good = 0;
            int n_re_data = 0;
            int n_commit = 0;
            int commit_at = -1;
            do_reset();
            fetch_addr = 32'h8; cpu_mwe = 1'b1; cpu_mre = (v == 1);
            cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678; dmem_word = 32'hA5A5_A5A5;
            supply_instr(32'hE581_0000, 1'b1, 32'h0);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (mem_we) begin
                    n_we++;
                    if (mem_addr == 32'h40 && mem_wdata == 32'h1234_5678) n_we_good++;
                end
                if (mem_re && mem_addr == 32'h40) n_re_data++;
                if (commit) begin
                    n_commit++;
                    commit_at = c;
                end
            end
            total++;
            if (n_we != 1 || n_we_good != 1 || n_re_data != 0) begin
                bad++;
                $display("FAIL store_access v%0d: we=%0d good=%0d re=%0d, required 1 1 0", v, n_we, n_we_good, n_re_data);
            end
            total++;
            if (n_commit != 1 || commit_at != 4) begin
                bad++;
                $display("FAIL store_commit v%0d: count=%0d cycle=%0d, required 1 at 4", v, n_commit, commit_at);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        fetch_addr = 32'h20; fetch_lat = 1000;
        supply_instr(32'hE1A0_0000, 1'b0, 32'h0);
        repeat (17) @(negedge clk);
        total++;
        if ({bus_err, mem_re} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_c16: bus_err=%b re=%b, required 0 1", bus_err, mem_re);
        end
        @(negedge clk);
        total++;
        if ({bus_err, mem_re, mem_addr, instret} !== {1'b1, 1'b1, 32'h20, 32'd0}) begin
            bad++;
            $display("FAIL timeout_c17: bus_err=%b re=%b addr=%h instret=%0d, required 1 1 20 0",
                     bus_err, mem_re, mem_addr, instret);
        end
        fetch_lat = 0;
        repeat (2) @(negedge clk);
        total++;
        if (commit !== 1'b1) begin
            bad++;
            $display("FAIL timeout_retry_commit: got %b, required 1", commit);
        end
        @(negedge clk);
        total++;
        if ({instret, bus_err} !== {32'd1, 1'b1}) begin
            bad++;
            $display("FAIL timeout_sticky: instret=%0d bus_err=%b, required 1 1", instret, bus_err);
        end

        do_reset();
        fetch_lat = 15;
        supply_instr(32'hE1A0_1001, 1'b0, 32'h0);
        repeat (18) @(negedge clk);
        total++;
        if ({commit, bus_err} !== 2'b10) begin
            bad++;
            $display("FAIL ready_on_last: commit=%b bus_err=%b, required 1 0", commit, bus_err);
        end
        @(negedge clk);
        total++;
        if ({instret, bus_err} !== {32'd1, 1'b0}) begin
            bad++;
            $display("FAIL ready_on_last_after: instret=%0d bus_err=%b, required 1 0", instret, bus_err);
        end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        fetch_addr = 32'h10; cpu_mwe = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h0BAD_F00D; data_lat = 1000;
        supply_instr(32'hE581_2000, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        total++;
        if (mem_we !== 1'b1) begin
            bad++;
            $display("FAIL midreset_data_phase: mem_we=%b, required 1", mem_we);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({mem_we, mem_re, commit} !== 3'b000) begin
            bad++;
            $display("FAIL midreset_gate: we/re/commit=%b, required 000", {mem_we, mem_re, commit});
        end
        @(negedge clk);
        total++;
        if ({instr, cpu_rdata, instret, cycles, bus_err} !== 129'h0) begin
            bad++;
            $display("FAIL midreset_values: instr=%h rdata=%h instret=%0d cycles=%0d bus_err=%b, required 0",
                     instr, cpu_rdata, instret, cycles, bus_err);
        end
        sb.delete();
        ifetch_q.delete();
        cpu_mwe = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (mem_re !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: mem_re=%b, required 0", mem_re);
        end
        @(negedge clk);
        total++;
        if ({mem_re, mem_addr} !== {1'b1, 32'h10}) begin
            bad++;
            $display("FAIL midreset_fetch: re=%b addr=%h, required 1 10", mem_re, mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            supply_instr(32'hE280_0000 | 32'(i), 1'b0, 32'h0);
        end
        repeat (201) @(posedge clk);
        @(negedge clk);
        total++;
        if ({instret, cycles} !== {32'd100, 32'd201}) begin
            bad++;
            $display("FAIL b2b_counters: instret=%0d cycles=%0d, required 100 201", instret, cycles);
        end
        total++;
        if (w_instret !== 32'h0000_0024) begin
            bad++;
            $display("FAIL b2b_instret_wrap: got %h, required 00000024", w_instret);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending: %0d commits outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        fetch_addr = 32'h0; cpu_mre = 1'b0; cpu_mwe = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        fork
            memory_model();
            commit_monitor();
        join_none
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid_store();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
